// File: rtl/sid_env_vca.sv
// -----------------------------------------------------------------------------
// sid_env_vca
//   Voice amplitude stage that sits directly after the envelope generator.
//   On each SID tick (clk_en) it samples the unsigned waveform code and the
//   envelope level. It converts the waveform from offset-binary to two's
//   complement, then multiplies the two with a serial shift-add unit that
//   handles one envelope bit per clock. The signed product goes to the voice
//   mixer.
//
//   Ports
//     clk        in   1       system clock
//     n_reset    in   1       asynchronous reset, active-low
//     clk_en     in   1       SID tick strobe; requests a new product
//     wave       in   WAVE_W  unsigned waveform code (midscale = 2**(WAVE_W-1))
//     env        in   ENV_W   envelope level
//     mute       in   1       voice mute; forces the product to 0
//     amp_out    out  OUT_W   signed product, held between updates
//     out_valid  out  1       one-clock pulse when amp_out updates
//     busy       out  1       high while a multiply is in progress
//     overrun    out  1       sticky; clk_en arrived while busy
//
//   Timing: capture edge E0, multiply edges E1..E(ENV_W), and the result
//   edge E(ENV_W+1). A new tick is accepted on the edge that follows the
//   result edge.
// -----------------------------------------------------------------------------
module sid_env_vca #(
   parameter int WAVE_W = 12,
   parameter int ENV_W  = 8,
   parameter int OUT_W  = 20   // must equal WAVE_W + ENV_W
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              clk_en,
   input  logic [WAVE_W-1:0] wave,
   input  logic [ENV_W-1:0]  env,
   input  logic              mute,
   output logic [OUT_W-1:0]  amp_out,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun
);

   localparam int CNT_W = (ENV_W > 1) ? $clog2(ENV_W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [WAVE_W-1:0]  wave_s;   // captured waveform, two's complement
   logic [ENV_W-1:0]   env_r;
   logic               mute_r;
   logic [OUT_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic [OUT_W-1:0]   wave_ext;
   logic               last_bit;

   // Sign-extend the captured waveform to the full product width. Each
   // partial product is then a plain shift of this value, and the
   // accumulator wraps naturally at OUT_W bits.
   assign wave_ext = {{ENV_W{wave_s[WAVE_W-1]}}, wave_s};
   assign last_bit = (cnt == CNT_W'(ENV_W - 1));
   assign busy     = (state != IDLE);

   // State register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         // NOTE: registers use non-blocking assignments, so every flop samples
         // the pre-edge values of the others regardless of statement order.
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: the default comes first so that every path assigns state_next,
      // which keeps this block purely combinational (no latch).
      state_next = state;
      case (state)
         IDLE:    if (clk_en)   state_next = MUL;
         MUL:     if (last_bit) state_next = DONE;
         DONE:                  state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   // Datapath: input capture, shift-add iterations, result and flags
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wave_s    <= '0;
         env_r     <= '0;
         mute_r    <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         amp_out   <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;

         // A tick that lands while a product is in flight is dropped but remembered.
         if (clk_en && (state != IDLE)) begin
            overrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (clk_en) begin
                  // Offset-binary to two's complement: invert the MSB.
                  wave_s <= {~wave[WAVE_W-1], wave[WAVE_W-2:0]};
                  env_r  <= env;
                  mute_r <= mute;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            MUL: begin
               if (env_r[cnt]) begin
                  acc <= acc + (wave_ext << cnt);
               end
               cnt <= cnt + CNT_W'(1);
            end
            DONE: begin
               amp_out   <= mute_r ? '0 : acc;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
